// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - start/operand/result bundle for seq_multiplier
// signed_op exists only when SEQ_MULT_SIGNED_EN is defined.
interface seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
`ifdef SEQ_MULT_SIGNED_EN
  logic               signed_op;
`endif
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

`ifdef SEQ_MULT_SIGNED_EN
  modport master (output start, a, b, signed_op, input busy, done, product);
  modport slave  (input start, a, b, signed_op, output busy, done, product);
`else
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
`endif
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-and-add multiplier, WIDTH CALC cycles per product
// Define SEQ_MULT_SIGNED_EN to add two's-complement operands via signed_op.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  seq_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_product;
  logic [CW-1:0]      r_count;
  logic               r_busy;
  logic               r_done;
  logic               r_neg;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_result;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_neg;

  // Magnitudes fit in WIDTH bits even for -2^(WIDTH-1), so the datapath stays unsigned.
`ifdef SEQ_MULT_SIGNED_EN
  assign w_a_mag = (bus.signed_op && bus.a[WIDTH-1]) ? (~bus.a + ONE_W) : bus.a;
  assign w_b_mag = (bus.signed_op && bus.b[WIDTH-1]) ? (~bus.b + ONE_W) : bus.b;
  assign w_neg   = bus.signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`else
  assign w_a_mag = bus.a;
  assign w_b_mag = bus.b;
  assign w_neg   = 1'b0;
`endif

  // Add into the upper WIDTH+1 bits, then drop the retired LSB.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
  assign w_result   = r_neg ? (~w_acc_next + ONE_2W) : w_acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_neg     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_neg    <= w_neg;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            r_product <= w_result;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - table, random and corner-sequence checks for seq_multiplier
// Signed vectors are added when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(8))  if8();
  seq_multiplier_if #(.WIDTH(16)) if16();

  seq_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  seq_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: the mathematical product reduced to 16 bits.
  function automatic longint model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int sa, sb;
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    return longint'((sa * sb) & 32'hFFFF);
  endfunction

  task automatic set_signed8(input logic s);
`ifdef SEQ_MULT_SIGNED_EN
    if8.signed_op = s;
`else
    if (s) $display("note: signed vector requested in unsigned build");
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on the 8-bit unit; accept edge is counted as edge 1.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input longint exp, input string name);
    int busy_n, done_n, done_at, overlap;
    if8.a = a;
    if8.b = b;
    set_signed8(s);
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    if8.a = 8'($urandom);
    if8.b = 8'($urandom);
    set_signed8(1'($urandom));
    busy_n  = if8.busy ? 1 : 0;
    done_n  = 0;
    done_at = -1;
    overlap = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (if8.busy) busy_n++;
      if (if8.done) begin
        done_n++;
        if (done_at < 0) done_at = k + 1;
      end
      if (if8.busy && if8.done) overlap++;
    end
    check({name, " product"}, longint'(if8.product), exp);
    check({name, " busy_cycles"}, busy_n, 8);
    check({name, " done_pulses"}, done_n, 1);
    check({name, " done_edge"}, done_at, 9);
    check({name, " busy_done_overlap"}, overlap, 0);
  endtask

  initial begin
    int done_edges[$];
    int busy_n, done_n;
    logic [7:0] ra, rb;
    logic rs;

    if8.start = 1'b0;  if8.a = '0;  if8.b = '0;
    if16.start = 1'b0; if16.a = '0; if16.b = '0;
`ifdef SEQ_MULT_SIGNED_EN
    if8.signed_op = 1'b0;
    if16.signed_op = 1'b0;
`endif

    vecs.push_back('{8'd13,  8'd11,  1'b0, 16'd143});
    vecs.push_back('{8'd255, 8'd255, 1'b0, 16'd65025});
    vecs.push_back('{8'd0,   8'd200, 1'b0, 16'd0});
    vecs.push_back('{8'd1,   8'd1,   1'b0, 16'd1});
    vecs.push_back('{8'd128, 8'd2,   1'b0, 16'd256});
    vecs.push_back('{8'd200, 8'd0,   1'b0, 16'd0});
`ifdef SEQ_MULT_SIGNED_EN
    vecs.push_back('{8'hFB,  8'd7,   1'b1, 16'hFFDD});
    vecs.push_back('{8'h80,  8'h80,  1'b1, 16'd16384});
    vecs.push_back('{8'hFB,  8'd7,   1'b0, 16'd1757});
    vecs.push_back('{8'h80,  8'h01,  1'b1, 16'hFF80});
    vecs.push_back('{8'h7F,  8'h81,  1'b1, 16'd49407});
`endif

    #1 rst = 1'b1;
    #1;
    check("reset busy", if8.busy, 0);
    check("reset done", if8.done, 0);
    check("reset product", longint'(if8.product), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i])
      do_op8(vecs[i].a, vecs[i].b, vecs[i].s, longint'(vecs[i].exp), $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      do_op8(ra, rb, rs, model8(ra, rb, rs), $sformatf("rand%0d", i));
    end

    // start held high: starts during CALC/DONE must not shorten the period
    if8.a = 8'd3;
    if8.b = 8'd5;
    set_signed8(1'b0);
    if8.start = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (if8.done) begin
        done_edges.push_back(k);
        check($sformatf("held product@%0d", k), longint'(if8.product), 15);
      end
    end
    if8.start = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    check("held done_count", done_edges.size(), 3);
    if (done_edges.size() == 3) begin
      check("held period1", done_edges[1] - done_edges[0], 10);
      check("held period2", done_edges[2] - done_edges[1], 10);
    end

    // asynchronous reset in the 4th CALC cycle
    if8.a = 8'd200;
    if8.b = 8'd100;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("abort busy", if8.busy, 0);
    check("abort done", if8.done, 0);
    check("abort product", longint'(if8.product), 0);
    tick();
    rst = 1'b0;
    done_n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (if8.done) done_n++;
    end
    check("abort no_done", done_n, 0);
    do_op8(8'd7, 8'd6, 1'b0, 42, "post_reset");

    // 16-bit instance
    if16.a = 16'd65535;
    if16.b = 16'd2;
    if16.start = 1'b1;
    tick();
    if16.start = 1'b0;
    busy_n = if16.busy ? 1 : 0;
    done_n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (if16.busy) busy_n++;
      if (if16.done) done_n++;
    end
    check("w16 busy_cycles", busy_n, 16);
    check("w16 done_pulses", done_n, 1);
    check("w16 product", longint'(if16.product), 131070);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
